// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging blocks: FSM state encoding
// and default timing constants at 100 MHz.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    localparam int DEF_CNT_W        = 32;
    localparam int DEF_TRIG_CYCLES  = 1000;
    localparam int DEF_ECHO_TIMEOUT = 3800000;
    localparam int DEF_HOLDOFF      = 6000000;
    localparam int TRIG_COUNT_W     = 16;

endpackage

// File: rtl/ultrasonic_trig_if.sv
// Control and sensor signals of the ultrasonic trigger block.
interface ultrasonic_trig_if;
    import ultrasonic_pkg::*;

    logic                    start;
    logic                    periodic_en;
    logic                    echo_in;
    logic                    trig_out;
    logic                    busy;
    logic                    done;
    logic                    timeout;
    logic [TRIG_COUNT_W-1:0] trig_count;

    modport master (
        output start, periodic_en, echo_in,
        input  trig_out, busy, done, timeout, trig_count
    );

    modport slave (
        input  start, periodic_en, echo_in,
        output trig_out, busy, done, timeout, trig_count
    );

endinterface

// File: rtl/ultrasonic_trig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a delay
// flop so that single-cycle rise and fall strobes can be derived.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              delay_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
        end
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q[gi] <= 1'b0;
            end else begin
                sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_q <= 1'b0;
        end else begin
            delay_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~delay_q;
    assign fall_o = ~sync_q[STAGES-1] &  delay_q;

endmodule

// File: rtl/ultrasonic_trig.sv
// Ultrasonic transmit side: issues the trigger pulse, frames the echo window
// (echo complete or timeout), then enforces a holdoff before the next shot.
module ultrasonic_trig
    import ultrasonic_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
    parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
    parameter int HOLDOFF      = DEF_HOLDOFF
) (
    input  logic               clk,
    input  logic               rst,
    ultrasonic_trig_if.slave   bus
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    trig_q, trig_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic [TRIG_COUNT_W-1:0] count_q, count_d;

    logic echo_rise;
    logic echo_fall;
    logic req;

    sync_edge #(.STAGES(2)) u_echo_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.echo_in),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    assign req = bus.start | bus.periodic_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // The window counter keeps running across the rise; >= covers a
            // rise landing exactly on the last window cycle.
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_WAIT_FALL;
                    cnt_d   = cnt_q + CNT_ONE;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_FALL: begin
                if (echo_fall || (cnt_q >= TO_LAST)) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HO_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        trig_d    = (state_d == ST_TRIG);
        busy_d    = (state_d != ST_IDLE);
        done_d    = 1'b0;
        timeout_d = 1'b0;
        count_d   = count_q;
        if ((state_q == ST_IDLE) && req) begin
            count_d = count_q + TRIG_COUNT_W'(1);
        end
        // A fall on the final window cycle still counts as a good echo.
        if (((state_q == ST_WAIT_RISE) || (state_q == ST_WAIT_FALL)) &&
            (state_d == ST_HOLDOFF)) begin
            done_d    = 1'b1;
            timeout_d = ~((state_q == ST_WAIT_FALL) && echo_fall);
        end
    end

    assign bus.trig_out   = trig_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.trig_count = count_q;

endmodule

// File: tb/tb_ultrasonic_trig.sv
// Directed bench for ultrasonic_trig: echo-window vectors from a table,
// then periodic mode, reset abort and trigger counter wrap.
module tb_ultrasonic_trig;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clk_f = 1'b0;
    logic rst_f = 1'b1;

    always #5 clk   = ~clk;
    always #1 clk_f = ~clk_f;

    ultrasonic_trig_if bus ();
    ultrasonic_trig_if bus_f ();

    ultrasonic_trig #(
        .CNT_W(32), .TRIG_CYCLES(4), .ECHO_TIMEOUT(20), .HOLDOFF(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ultrasonic_trig #(
        .CNT_W(32), .TRIG_CYCLES(1), .ECHO_TIMEOUT(1), .HOLDOFF(1)
    ) dut_fast (
        .clk (clk_f),
        .rst (rst_f),
        .bus (bus_f.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // n counts posedges after the one that samples start (n=0). Echo is
    // driven high for negedges a <= n < b; dn is the expected done cycle.
    typedef struct {
        int a;
        int b;
        int sb;
        int dn;
        bit to;
    } vec_t;

    vec_t tbl [6];
    logic [15:0] exp_cnt;

    initial begin
        int rises [$];
        int ndone;
        int nto;
        logic prev;
        int nrise;
        bit wrapped;

        tbl[0] = '{a: 7,    b: 13,   sb: -1, dn: 16, to: 1'b0};
        tbl[1] = '{a: 1000, b: 1000, sb: -1, dn: 24, to: 1'b1};
        tbl[2] = '{a: 1,    b: 26,   sb: 10, dn: 24, to: 1'b1};
        tbl[3] = '{a: 18,   b: 21,   sb: -1, dn: 24, to: 1'b0};
        tbl[4] = '{a: 18,   b: 22,   sb: -1, dn: 24, to: 1'b1};
        tbl[5] = '{a: -1,   b: 26,   sb: -1, dn: 24, to: 1'b1};

        bus.start = 1'b0;  bus.periodic_en = 1'b0;  bus.echo_in = 1'b0;
        bus_f.start = 1'b0; bus_f.periodic_en = 1'b0; bus_f.echo_in = 1'b0;
        exp_cnt = 16'd0;

        repeat (3) @(negedge clk);
        chk("reset_trig",    {31'b0, bus.trig_out}, 32'd0);
        chk("reset_busy",    {31'b0, bus.busy},     32'd0);
        chk("reset_done",    {31'b0, bus.done},     32'd0);
        chk("reset_timeout", {31'b0, bus.timeout},  32'd0);
        chk("reset_count",   {16'b0, bus.trig_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            int errs_before;
            errs_before = errors;
            if (tbl[v].a < 0) begin
                bus.echo_in = 1'b1;
                repeat (5) @(negedge clk);
            end
            bus.start = 1'b1;
            for (int n = 0; n <= tbl[v].dn + 6; n++) begin
                @(negedge clk);
                chk($sformatf("v%0d_n%0d_trig", v, n), {31'b0, bus.trig_out}, 32'(n < 4));
                chk($sformatf("v%0d_n%0d_done", v, n), {31'b0, bus.done}, 32'(n == tbl[v].dn));
                chk($sformatf("v%0d_n%0d_timeout", v, n), {31'b0, bus.timeout},
                    32'((n == tbl[v].dn) && tbl[v].to));
                chk($sformatf("v%0d_n%0d_busy", v, n), {31'b0, bus.busy}, 32'(n <= tbl[v].dn + 4));
                bus.start   = (n == tbl[v].sb);
                bus.echo_in = (n >= tbl[v].a) && (n < tbl[v].b);
            end
            exp_cnt = exp_cnt + 16'd1;
            chk($sformatf("v%0d_trig_count", v), {16'b0, bus.trig_count}, {16'b0, exp_cnt});
            bus.echo_in = 1'b0;
            repeat (4) @(negedge clk);
            $display("vector %0d echo[%0d,%0d) done@%0d timeout=%0d errors_in_vector=%0d",
                     v, tbl[v].a, tbl[v].b, tbl[v].dn, tbl[v].to, errors - errs_before);
        end

        // Periodic mode with echo low; disabled during the third window.
        prev = 1'b0; ndone = 0; nto = 0;
        bus.periodic_en = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            if (bus.trig_out && !prev) rises.push_back(n);
            prev = bus.trig_out;
            if (bus.done) ndone++;
            if (bus.timeout) nto++;
            if (n == 70) bus.periodic_en = 1'b0;
        end
        chk("periodic_num_triggers", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            chk("periodic_rise0", 32'(rises[0]), 32'd0);
            chk("periodic_rise1", 32'(rises[1]), 32'd30);
            chk("periodic_rise2", 32'(rises[2]), 32'd60);
        end
        chk("periodic_done_count", 32'(ndone), 32'd3);
        chk("periodic_timeout_count", 32'(nto), 32'd3);
        chk("periodic_idle_busy", {31'b0, bus.busy}, 32'd0);
        exp_cnt = exp_cnt + 16'd3;
        chk("periodic_trig_count", {16'b0, bus.trig_count}, {16'b0, exp_cnt});
        $display("periodic triggers=%0d done=%0d timeouts=%0d", rises.size(), ndone, nto);

        // Reset sampled on the third TRIG cycle aborts without a done.
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst_n0_trig", {31'b0, bus.trig_out}, 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_n1_trig", {31'b0, bus.trig_out}, 32'd1);
        chk("rst_n1_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_trig",  {31'b0, bus.trig_out}, 32'd0);
        chk("rst_abort_busy",  {31'b0, bus.busy},     32'd0);
        chk("rst_abort_count", {16'b0, bus.trig_count}, 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done || bus.trig_out || bus.busy) ndone++;
        end
        chk("rst_no_activity_after_abort", 32'(ndone), 32'd0);
        $display("reset abort activity_after=%0d", ndone);

        // Fast instance free-runs in periodic mode to exercise the wrap.
        @(negedge clk_f);
        rst_f = 1'b0;
        bus_f.periodic_en = 1'b1;
        prev = 1'b0; nrise = 0; wrapped = 1'b0;
        for (int c = 0; c < 300000 && !wrapped; c++) begin
            @(negedge clk_f);
            if (bus_f.trig_out && !prev) begin
                nrise++;
                if (nrise == 1)
                    chk("wrap_first", {16'b0, bus_f.trig_count}, 32'h0001);
                if (nrise == 65535)
                    chk("wrap_ffff", {16'b0, bus_f.trig_count}, 32'hFFFF);
                if (nrise == 65536) begin
                    chk("wrap_zero", {16'b0, bus_f.trig_count}, 32'h0000);
                    wrapped = 1'b1;
                end
            end
            prev = bus_f.trig_out;
        end
        bus_f.periodic_en = 1'b0;
        if (!wrapped) begin
            checks++;
            errors++;
            $display("FAIL wrap_budget triggers_seen=%0d required=65536", nrise);
        end
        $display("wrap triggers=%0d count=%0h", nrise, bus_f.trig_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
